// File: rtl/sobel_window_gen.sv
// Raster-scan 3x3 window generator for a Sobel stage: two line buffers plus a
// three-column shift register, with zero padding at the image borders.
module sobel_window_gen #(
  parameter int WIDTH          = 768,
  parameter int HEIGHT         = 512,
  parameter int BITS_FOR_INDEX = 10,
  parameter int sizeOfWidth    = 8
) (
  input  logic                      CAMERA_CLK,
  input  logic                      rst,
  input  logic                      frame_start,
  input  logic [sizeOfWidth-1:0]    pixel_in,
  input  logic                      pixel_valid,
  output logic                      pixel_ready,
  output logic [sizeOfWidth-1:0]    ul,
  output logic [sizeOfWidth-1:0]    uc,
  output logic [sizeOfWidth-1:0]    ur,
  output logic [sizeOfWidth-1:0]    ml,
  output logic [sizeOfWidth-1:0]    mc,
  output logic [sizeOfWidth-1:0]    mr,
  output logic [sizeOfWidth-1:0]    dl,
  output logic [sizeOfWidth-1:0]    dc,
  output logic [sizeOfWidth-1:0]    dr,
  output logic [BITS_FOR_INDEX-1:0] rowIndex,
  output logic [BITS_FOR_INDEX-1:0] colIndex,
  output logic                      readWrite,
  output logic                      frame_done
);

  localparam int COL_AW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef logic [sizeOfWidth-1:0]    pix_t;
  typedef logic [BITS_FOR_INDEX-1:0] idx_t;
  typedef enum logic [1:0] {IDLE, FILL, STREAM, FLUSH} state_t;
  typedef struct packed {
    pix_t u;
    pix_t m;
    pix_t d;
  } column_t;

  localparam idx_t LAST_COL  = idx_t'(WIDTH - 1);
  localparam idx_t LAST_ROW  = idx_t'(HEIGHT - 1);
  localparam idx_t FLUSH_ROW = idx_t'(HEIGHT - 2);
  localparam idx_t LAST_FLUSH = idx_t'(WIDTH);
  localparam idx_t ONE       = idx_t'(1);

  state_t  state;
  idx_t    in_row, in_col, flush_cnt;
  logic    flush_done;
  pix_t    line1 [WIDTH];
  pix_t    line2 [WIDTH];
  column_t col1, col2;

  logic [COL_AW-1:0] lb_addr;
  pix_t top, mid;
  logic accept, top_edge, left_edge;

  assign pixel_ready = (state == FILL) || (state == STREAM);
  assign accept      = pixel_valid && pixel_ready && !frame_start;
  assign lb_addr     = in_col[COL_AW-1:0];
  assign top         = line2[lb_addr];
  assign mid         = line1[lb_addr];
  assign top_edge    = (in_row == ONE);
  assign left_edge   = (in_col == ONE);

  // NOTE: line buffers and the column shift register carry no reset; stale
  // contents only ever reach taps that the border masking forces to zero.
  always_ff @(posedge CAMERA_CLK) begin
    if (accept && !rst) begin
      line2[lb_addr] <= mid;
      line1[lb_addr] <= pixel_in;
      col2           <= col1;
      col1           <= '{u: top, m: mid, d: pixel_in};
    end
  end

  // NOTE: all state here uses non-blocking assignments so every register
  // samples pre-edge values, regardless of statement order.
  always_ff @(posedge CAMERA_CLK) begin
    if (rst) begin
      state      <= IDLE;
      in_row     <= '0;
      in_col     <= '0;
      flush_cnt  <= '0;
      flush_done <= 1'b0;
      frame_done <= 1'b0;
      readWrite  <= 1'b1;
      rowIndex   <= '0;
      colIndex   <= '0;
      {ul, uc, ur, ml, mc, mr, dl, dc, dr} <= '0;
    end else begin
      readWrite  <= 1'b1;
      frame_done <= flush_done;
      flush_done <= 1'b0;
      if (frame_start) begin
        state     <= FILL;
        in_row    <= '0;
        in_col    <= '0;
        flush_cnt <= '0;
      end else begin
        case (state)
          FILL, STREAM: begin
            if (pixel_valid) begin
              if (in_row != '0 && in_col != '0) begin
                readWrite <= 1'b0;
                rowIndex  <= in_row - ONE;
                colIndex  <= in_col - ONE;
                ul <= (top_edge || left_edge) ? '0 : col2.u;
                uc <= top_edge  ? '0 : col1.u;
                ur <= top_edge  ? '0 : top;
                ml <= left_edge ? '0 : col2.m;
                mc <= col1.m;
                mr <= mid;
                dl <= left_edge ? '0 : col2.d;
                dc <= col1.d;
                dr <= pixel_in;
              end else if (in_row > ONE && in_col == '0) begin
                // Right-edge window of the row two above: emitted all-zero.
                readWrite <= 1'b0;
                rowIndex  <= in_row - idx_t'(2);
                colIndex  <= LAST_COL;
                {ul, uc, ur, ml, mc, mr, dl, dc, dr} <= '0;
              end
              if (in_col == LAST_COL) begin
                in_col <= '0;
                in_row <= in_row + ONE;
                if (in_row == LAST_ROW) state <= FLUSH;
                else                    state <= STREAM;
              end else begin
                in_col <= in_col + ONE;
              end
            end
          end
          FLUSH: begin
            readWrite <= 1'b0;
            {ul, uc, ur, ml, mc, mr, dl, dc, dr} <= '0;
            if (flush_cnt == '0) begin
              rowIndex <= FLUSH_ROW;
              colIndex <= LAST_COL;
            end else begin
              rowIndex <= LAST_ROW;
              colIndex <= flush_cnt - ONE;
            end
            flush_cnt <= flush_cnt + ONE;
            if (flush_cnt == LAST_FLUSH) begin
              state      <= IDLE;
              flush_done <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
